// File: rtl/camino_datos.sv
// Booth radix-2 multiplier datapath: A/Q/q(-1)/M registers driven by control-unit micro-ops, plus product latch.
// Every micro-op completes on the edge it is sampled; producto appears one edge after Fin, no backpressure.
module camino_datos #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  input  logic                 CargaQ,
  input  logic                 CargaM,
  input  logic                 ResetA,
  input  logic                 CargaA,
  input  logic                 DesplazaAQ,
  input  logic                 Fin,
  output logic                 q0,
  output logic                 qsub1,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 producto_valido
);

  localparam int AW = WIDTH + 1;

  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               vld_q, vld_d;

  logic [AW-1:0]      a_sum;
  logic [AW-1:0]      a_step;
  logic               load_any;

  assign load_any = CargaQ | CargaM | ResetA;

  // Self-gated Booth step: 00/11 pairs leave A alone even if CargaA is asserted.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
  end

  assign a_step = CargaA ? a_sum : a_q;

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    if (load_any) begin
      if (ResetA) a_d = '0;
      if (CargaQ) begin
        q_d   = multiplicador;
        qm1_d = 1'b0;
      end
      if (CargaM) m_d = {multiplicando[WIDTH-1], multiplicando};
    end else if (DesplazaAQ) begin
      // Add/subtract result feeds the shift when both are requested together.
      a_d   = {a_step[AW-1], a_step[AW-1:1]};
      q_d   = {a_step[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end else begin
      a_d = a_step;
    end
  end

  always_comb begin
    prod_d = prod_q;
    vld_d  = vld_q;
    if (Fin) begin
      prod_d = {a_q[WIDTH-1:0], q_q};
      vld_d  = 1'b1;
    end else if (CargaQ) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      m_q    <= '0;
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      m_q    <= m_d;
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

  assign q0              = q_q[0];
  assign qsub1           = qm1_q;
  assign producto        = prod_q;
  assign producto_valido = vld_q;

endmodule

// File: tb/tb_camino_datos.sv
// Bench for camino_datos: drives a behavioural Booth control sequence and checks against signed arithmetic.
module tb_camino_datos;
  localparam int W  = 3;
  localparam int NE = 2 * W + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] multiplicando, multiplicador;
  logic                CargaQ, CargaM, ResetA, CargaA, DesplazaAQ, Fin;
  logic                q0, qsub1;
  logic [2*W-1:0]      producto;
  logic                producto_valido;

  int n_tests = 0;
  int n_fail  = 0;

  logic           vld_hist [1:NE];
  logic [2*W-1:0] prod_hist[1:NE];
  logic [1:0]     booth_hist[0:W-1];

  always #5 clk = ~clk;

  camino_datos #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .CargaQ(CargaQ), .CargaM(CargaM), .ResetA(ResetA), .CargaA(CargaA),
    .DesplazaAQ(DesplazaAQ), .Fin(Fin),
    .q0(q0), .qsub1(qsub1),
    .producto(producto), .producto_valido(producto_valido)
  );

  task automatic clear_ctl();
    CargaQ = 0; CargaM = 0; ResetA = 0; CargaA = 0; DesplazaAQ = 0; Fin = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control-unit behaviour: load, then W x (add, shift), then Fin; records outputs after each edge.
  task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input int stop_after);
    for (int e = 1; e <= stop_after; e++) begin
      clear_ctl();
      multiplicando = a;
      multiplicador = b;
      if (e == 1) begin
        CargaQ = 1; CargaM = 1; ResetA = 1;
      end else if (e == NE) begin
        Fin = 1;
      end else if (e % 2 == 0) begin
        CargaA = 1;
        booth_hist[(e - 2) / 2] = {q0, qsub1};
      end else begin
        DesplazaAQ = 1;
      end
      step();
      vld_hist[e]  = producto_valido;
      prod_hist[e] = producto;
    end
    clear_ctl();
  endtask

  task automatic test_reset();
    clear_ctl();
    multiplicando = '0;
    multiplicador = '0;
    reset = 0;
    #2;
    n_tests++; if (producto !== '0) begin n_fail++; $display("FAIL reset_prod: got %b expected 0", producto); end
    n_tests++; if (producto_valido !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", producto_valido); end
    n_tests++; if ({q0, qsub1} !== 2'b00) begin n_fail++; $display("FAIL reset_q: got %b expected 00", {q0, qsub1}); end
    step();
    reset = 1;
  endtask

  task automatic test_mult(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int             p;
    logic [2*W-1:0] exp_p;
    logic [1:0]     exp_pair;
    logic [W-1:0]   bb;
    p     = int'(a) * int'(b);
    exp_p = p[2*W-1:0];
    bb    = b;
    run_op(a, b, NE);
    for (int e = 1; e < NE; e++) begin
      n_tests++;
      if (vld_hist[e] !== 1'b0) begin
        n_fail++; $display("FAIL mult_early_vld %0d*%0d edge %0d: got %b expected 0", a, b, e, vld_hist[e]);
      end
    end
    n_tests++;
    if (vld_hist[NE] !== 1'b1) begin
      n_fail++; $display("FAIL mult_vld %0d*%0d: got %b expected 1", a, b, vld_hist[NE]);
    end
    n_tests++;
    if (prod_hist[NE] !== exp_p) begin
      n_fail++; $display("FAIL mult_prod %0d*%0d: got %b expected %b", a, b, prod_hist[NE], exp_p);
    end
    for (int i = 0; i < W; i++) begin
      exp_pair = {bb[i], (i == 0) ? 1'b0 : bb[i-1]};
      n_tests++;
      if (booth_hist[i] !== exp_pair) begin
        n_fail++; $display("FAIL booth_pair %0d*%0d iter %0d: got %b expected %b", a, b, i, booth_hist[i], exp_pair);
      end
    end
  endtask

  task automatic test_no_overflow();
    int         p;
    logic [W:0] exp_a;
    test_mult(-4, -4);
    p     = 16;
    exp_a = 4'(p >>> W);
    n_tests++; if (dut.m_q !== 4'b1100) begin n_fail++; $display("FAIL m_sext: got %b expected 1100", dut.m_q); end
    n_tests++; if (dut.a_q !== exp_a) begin n_fail++; $display("FAIL a_final: got %b expected %b", dut.a_q, exp_a); end
  endtask

  task automatic test_gating();
    clear_ctl(); CargaQ = 1; CargaM = 1; ResetA = 1; multiplicando = -1; multiplicador = 3'b111;
    step();
    n_tests++; if (dut.m_q !== 4'b1111) begin n_fail++; $display("FAIL gate_m: got %b expected 1111", dut.m_q); end
    n_tests++; if ({q0, qsub1} !== 2'b10) begin n_fail++; $display("FAIL gate_pair10: got %b expected 10", {q0, qsub1}); end
    for (int i = 0; i < 5; i++) begin
      clear_ctl(); CargaA = 1; step();
    end
    n_tests++; if (dut.a_q !== 4'b0101) begin n_fail++; $display("FAIL gate_build: got %b expected 0101", dut.a_q); end
    clear_ctl(); CargaQ = 1; CargaA = 1; multiplicador = 3'b000; step();
    n_tests++; if (dut.a_q !== 4'b0101) begin n_fail++; $display("FAIL gate_load_blocks: got %b expected 0101", dut.a_q); end
    n_tests++; if ({q0, qsub1} !== 2'b00) begin n_fail++; $display("FAIL gate_pair00: got %b expected 00", {q0, qsub1}); end
    clear_ctl(); CargaA = 1; step();
    n_tests++; if (dut.a_q !== 4'b0101) begin n_fail++; $display("FAIL gate_00: got %b expected 0101", dut.a_q); end
    clear_ctl(); CargaQ = 1; multiplicador = 3'b011; step();
    clear_ctl(); DesplazaAQ = 1; step();
    n_tests++; if (dut.a_q !== 4'b0010) begin n_fail++; $display("FAIL gate_shift: got %b expected 0010", dut.a_q); end
    n_tests++; if ({q0, qsub1} !== 2'b11) begin n_fail++; $display("FAIL gate_pair11: got %b expected 11", {q0, qsub1}); end
    clear_ctl(); CargaA = 1; step();
    n_tests++; if (dut.a_q !== 4'b0010) begin n_fail++; $display("FAIL gate_11: got %b expected 0010", dut.a_q); end
    clear_ctl(); CargaM = 1; DesplazaAQ = 1; multiplicando = 3'b011; step();
    n_tests++; if (dut.a_q !== 4'b0010) begin n_fail++; $display("FAIL gate_m_blocks_shift: got %b expected 0010", dut.a_q); end
    n_tests++; if (dut.m_q !== 4'b0011) begin n_fail++; $display("FAIL gate_m_load: got %b expected 0011", dut.m_q); end
    clear_ctl(); Fin = 1; step();
    n_tests++; if (producto !== 6'b010101) begin n_fail++; $display("FAIL gate_fin_prod: got %b expected 010101", producto); end
    clear_ctl(); CargaQ = 1; multiplicador = 3'b000; step();
    n_tests++; if (producto_valido !== 1'b0) begin n_fail++; $display("FAIL gate_cargaq_clr: got %b expected 0", producto_valido); end
    n_tests++; if (producto !== 6'b010101) begin n_fail++; $display("FAIL gate_prod_hold: got %b expected 010101", producto); end
    clear_ctl(); CargaQ = 1; Fin = 1; multiplicador = 3'b110; step();
    n_tests++; if (producto_valido !== 1'b1) begin n_fail++; $display("FAIL gate_fin_wins: got %b expected 1", producto_valido); end
    n_tests++; if (producto !== 6'b010000) begin n_fail++; $display("FAIL gate_fin_wins_prod: got %b expected 010000", producto); end
    clear_ctl(); step();
    n_tests++; if (dut.a_q !== 4'b0010) begin n_fail++; $display("FAIL gate_idle_hold: got %b expected 0010", dut.a_q); end
  endtask

  task automatic test_reset_mid();
    run_op(3, 2, 4);
    reset = 0;
    #1;
    n_tests++; if (producto !== '0) begin n_fail++; $display("FAIL mid_reset_prod: got %b expected 0", producto); end
    n_tests++; if (producto_valido !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vld: got %b expected 0", producto_valido); end
    n_tests++; if ({q0, qsub1} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_q: got %b expected 00", {q0, qsub1}); end
    step();
    reset = 1;
    test_mult(0, -1);
  endtask

  task automatic test_back_to_back();
    test_mult(3, 2);
    run_op(-4, 3, NE);
    for (int e = 1; e < NE; e++) begin
      n_tests++;
      if (vld_hist[e] !== 1'b0 || prod_hist[e] !== 6'b000110) begin
        n_fail++; $display("FAIL b2b_hold edge %0d: got vld=%b prod=%b expected vld=0 prod=000110", e, vld_hist[e], prod_hist[e]);
      end
    end
    n_tests++;
    if (vld_hist[NE] !== 1'b1 || prod_hist[NE] !== 6'b110100) begin
      n_fail++; $display("FAIL b2b_new: got vld=%b prod=%b expected vld=1 prod=110100", vld_hist[NE], prod_hist[NE]);
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      test_mult(a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult(3, 2);
    test_no_overflow();
    test_mult(-4, 3);
    test_gating();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/camino_datos.md
Name: camino_datos

Overview:
Datapath of the radix-2 Booth sequential signed multiplier. It holds the accumulator A, the multiplier register Q, the Booth bit q(-1) and the multiplicand M. It executes the micro-operations commanded by the multiplier's control unit (load, add/subtract, arithmetic shift) and returns q0/qsub1 to that unit. It also registers the final 2*WIDTH-bit signed product for the consumer.

Parameters:
WIDTH, 3, operand width in bits. Two's complement. The control unit performs exactly WIDTH add/shift iterations.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
multiplicando  input  WIDTH  signed multiplicand, sampled on CargaM
multiplicador  input  WIDTH  signed multiplier, sampled on CargaQ
CargaQ  input  1  load Q from multiplicador, clear q(-1)
CargaM  input  1  load M with multiplicando sign-extended to WIDTH+1
ResetA  input  1  clear A
CargaA  input  1  Booth add/subtract step on A
DesplazaAQ  input  1  arithmetic right shift of {A,Q,q(-1)}
Fin  input  1  control unit reports operation complete
q0  output  1  Q[0]
qsub1  output  1  q(-1) register
producto  output  2*WIDTH  signed product
producto_valido  output  1  producto holds the result of the last operation

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (reset=0), immediate: A=0, Q=0, q(-1)=0, M=0, producto=0, producto_valido=0. q0=0 and qsub1=0.
- Register widths: A and M are WIDTH+1 bits; M is stored sign-extended. Q is WIDTH bits; q(-1) is 1 bit. All arithmetic is modulo 2^(WIDTH+1) and the carry out is discarded. The extra bit guarantees no overflow, including for M = -2^(WIDTH-1).
- Priority per rising edge:
  - Group 1 (highest): CargaQ / CargaM / ResetA. These act independently and may all be asserted in the same cycle. Any of them asserted blocks CargaA and DesplazaAQ in that cycle.
  - Group 2: CargaA. If {q0,qsub1}=01, A <= A+M. If 10, A <= A-M. If 00 or 11, A holds. The datapath self-gates CargaA, so CargaA asserted on 00/11 must not change A.
  - Group 3: DesplazaAQ. A <= {A[WIDTH],A[WIDTH:1]}, Q <= {A[0],Q[WIDTH-1:1]}, qsub1 <= Q[0].
  - CargaA together with DesplazaAQ (not issued by the current control unit): the add/subtract result is computed first and then shifted, all in the same edge.
- No control asserted: every register holds.
- Result: while Fin=1 at a rising edge, producto <= {A[WIDTH-1:0],Q} and producto_valido <= 1.
  - Latency: one cycle after Fin is first seen.
  - Fin held high re-latches the same value; this is harmless.
- CargaQ clears producto_valido, unless Fin=1 in the same cycle, in which case Fin wins. producto keeps its old value until the next Fin.
- q0/qsub1 are combinational from registers only; there is no combinational path from the control inputs.
- Reset mid-operation: all state cleared immediately, and no partial product ever appears on producto.
- Complete operation with the control unit: loads on edge 1, iterations on edges 2-7, producto_valido rises on edge 8 after reset release.

Test Plan:
- W=3, 3 x 2, full run with the control unit -> producto=000110 (6), producto_valido=1 exactly at edge 8, and 0 before it.
- -4 x -4 -> producto=010000 (+16). Check A's sign-extension bit and the absence of overflow on A-M.
- -4 x 3 -> producto=110100 (-12). Check q0/qsub1 = 10 before the subtract step and 01 before the add step.
- Directed CargaA pulses with {q0,qsub1}=00 and 11, A=0101 -> A unchanged. CargaA and CargaQ together -> only the load occurs.
- Assert reset=0 after edge 4 of the 3 x 2 run -> all outputs 0 immediately. After release, 0 x -1 -> producto=000000, valid at edge 8.
- Back-to-back operations: CargaQ while valid=1 -> producto_valido falls on that edge and producto keeps the old value until the new Fin.
